// File: rtl/imem_fetch_pkg.sv
// Shared definitions for the instruction-fetch sequencer.
//   XLEN          : address / instruction width
//   INSTR_NOP     : word presented on if_instr while nothing is buffered
//   PC_STEP       : byte increment between sequential fetches
//   fetch_state_t : RUN issues from fetch_pc; HOLD keeps a stalled request alive
package imem_fetch_pkg;

    localparam int              XLEN      = 32;
    localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding returned instruction words (PCs are tracked outside).
// Ports:
//   clk, rst        : clock, asynchronous active-low reset (pointers/count only)
//   flush           : drop every entry; wins over push and pop
//   push, wdata     : write one word
//   pop             : remove the head word (ignored when empty)
//   rdata           : head word (meaningful only when !empty)
//   empty, full     : occupancy flags
//   count           : number of valid entries, 0..DEPTH
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign count   = count_q;
    assign rdata   = mem[rd_ptr];

    // A pop frees the slot a same-cycle push needs, so push on full is fine then.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer between IF and an Avalon-style instruction bus.
// Keeps up to FIFO_DEPTH reads in flight, buffers returned words, hands decode
// one {pc, instr} per handshake and discards stale responses after a redirect.
// Optional build macro: IMEM_FETCH_PERF_EN adds saturating perf counters.
// Ports:
//   clk, rst                 : clock, asynchronous active-low reset
//   redirect_valid/_pc       : restart fetch at redirect_pc (low bits forced 0)
//   if_valid/if_instr/if_pc  : head of prefetch buffer towards decode
//   if_ready                 : decode accepts the head this cycle
//   imem_addr/imem_read      : read request (held while imem_waitrequest)
//   imem_waitrequest         : memory stall
//   imem_rdata/_valid        : in-order read responses
//   perf_*_cnt               : (IMEM_FETCH_PERF_EN only) wait/flush/drop counters
module imem_fetch_ctrl
    import imem_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        if_ready,
    output logic [31:0] imem_addr,
    output logic        imem_read,
    input  logic        imem_waitrequest,
    input  logic [31:0] imem_rdata,
    input  logic        imem_rdata_valid
`ifdef IMEM_FETCH_PERF_EN
    ,
    output logic [31:0] perf_wait_cnt,
    output logic [31:0] perf_flush_cnt,
    output logic [31:0] perf_drop_cnt
`endif
);

    localparam int         CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

    fetch_state_t    state, state_nx;
    logic [XLEN-1:0] fetch_pc, fetch_pc_nx;
    logic [XLEN-1:0] head_pc, head_pc_nx;
    logic [XLEN-1:0] hold_addr, hold_addr_nx;
    logic [CW-1:0]   outstanding, outstanding_nx;
    logic [CW-1:0]   discard, discard_nx;

    logic [CW-1:0]   fifo_count;
    logic            fifo_empty;
    logic            fifo_full;
    logic [XLEN-1:0] fifo_rdata;

    logic [XLEN-1:0] redir_pc;
    logic            issue_ok;
    logic            accept;
    logic            resp;
    logic            drop;
    logic            push;
    logic            pop;
    logic            unused_redir_lsb;

    assign redir_pc         = {redirect_pc[31:2], 2'b00};
    assign unused_redir_lsb = ^redirect_pc[1:0];

    // Every slot is reserved at issue time, so a response always finds room.
    assign issue_ok  = ({1'b0, fifo_count} + {1'b0, outstanding}) < DEPTH_W;
    assign imem_read = rst & ((state == HOLD) | issue_ok);
    assign imem_addr = (state == HOLD) ? hold_addr : fetch_pc;
    assign accept    = imem_read & ~imem_waitrequest;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign resp = imem_rdata_valid & (outstanding != '0);
    assign drop = resp & ((discard != '0) | redirect_valid);
    assign push = resp & (discard == '0) & ~redirect_valid;
    assign pop  = if_valid & if_ready & ~redirect_valid;

    assign if_valid = ~fifo_empty;
    assign if_pc    = head_pc;
    assign if_instr = fifo_empty ? INSTR_NOP : fifo_rdata;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (XLEN)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_valid),
        .push  (push),
        .wdata (imem_rdata),
        .pop   (pop),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    always_comb begin
        state_nx       = state;
        fetch_pc_nx    = fetch_pc;
        head_pc_nx     = head_pc;
        hold_addr_nx   = hold_addr;
        outstanding_nx = outstanding + CW'(accept) - CW'(resp);
        // In HOLD the accepted request belongs to the old stream, so it is
        // born stale.
        discard_nx     = discard - CW'(resp && (discard != '0))
                                 + CW'((state == HOLD) && accept);

        if (pop) head_pc_nx = head_pc + PC_STEP;

        case (state)
            RUN: begin
                hold_addr_nx = fetch_pc;
                if (accept) fetch_pc_nx = fetch_pc + PC_STEP;
                if (redirect_valid) begin
                    fetch_pc_nx = redir_pc;
                    head_pc_nx  = redir_pc;
                    // Everything still in flight after this edge is stale.
                    discard_nx  = outstanding_nx;
                    if (imem_read && imem_waitrequest) state_nx = HOLD;
                end
            end
            HOLD: begin
                if (accept) state_nx = RUN;
                if (redirect_valid) begin
                    fetch_pc_nx = redir_pc;
                    head_pc_nx  = redir_pc;
                end
            end
            default: state_nx = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= RUN;
            fetch_pc    <= RESET_PC;
            head_pc     <= RESET_PC;
            hold_addr   <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            state       <= state_nx;
            fetch_pc    <= fetch_pc_nx;
            head_pc     <= head_pc_nx;
            hold_addr   <= hold_addr_nx;
            outstanding <= outstanding_nx;
            discard     <= discard_nx;
        end
    end

`ifdef IMEM_FETCH_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_wait_cnt  <= '0;
            perf_flush_cnt <= '0;
            perf_drop_cnt  <= '0;
        end else begin
            perf_wait_cnt  <= sat_inc(perf_wait_cnt, imem_read & imem_waitrequest);
            perf_flush_cnt <= sat_inc(perf_flush_cnt, redirect_valid);
            perf_drop_cnt  <= sat_inc(perf_drop_cnt, drop);
        end
    end
`endif

    a_rsp_without_req: assert property (@(posedge clk) disable iff (!rst)
        !(imem_rdata_valid && (outstanding == '0)));

    a_push_into_full: assert property (@(posedge clk) disable iff (!rst)
        !(push && fifo_full && !pop));

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
module tb_imem_fetch_ctrl;
    import imem_fetch_pkg::*;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;
    logic [31:0] imem_addr;
    logic        imem_read;
    logic        imem_waitrequest;
    logic [31:0] imem_rdata;
    logic        imem_rdata_valid;
`ifdef IMEM_FETCH_PERF_EN
    logic [31:0] perf_wait_cnt;
    logic [31:0] perf_flush_cnt;
    logic [31:0] perf_drop_cnt;
`endif

    int          n_chk = 0;
    int          n_err = 0;
    int          lat = 1;
    int          stall_req = 0;
    logic [31:0] stall_addr = 32'h0;
    int          stall_used;
    int          acc8;
    exp_t        q[$];

    logic [1:0]  sv;
    logic [31:0] sd0, sd1;

    always #5 clk = ~clk;

    imem_fetch_ctrl #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (4)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .if_valid         (if_valid),
        .if_instr         (if_instr),
        .if_pc            (if_pc),
        .if_ready         (if_ready),
        .imem_addr        (imem_addr),
        .imem_read        (imem_read),
        .imem_waitrequest (imem_waitrequest),
        .imem_rdata       (imem_rdata),
        .imem_rdata_valid (imem_rdata_valid)
`ifdef IMEM_FETCH_PERF_EN
        ,
        .perf_wait_cnt    (perf_wait_cnt),
        .perf_flush_cnt   (perf_flush_cnt),
        .perf_drop_cnt    (perf_drop_cnt)
`endif
    );

    // Memory contents: each word is its address with a fixed tag in the top half.
    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    assign imem_waitrequest = (stall_used < stall_req) && (imem_addr == stall_addr);
    assign imem_rdata_valid = (lat == 1) ? sv[0] : sv[1];
    assign imem_rdata       = (lat == 1) ? sd0 : sd1;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            sv         <= 2'b00;
            sd0        <= 32'h0;
            sd1        <= 32'h0;
            stall_used <= 0;
            acc8       <= 0;
        end else begin
            sv[0] <= imem_read && !imem_waitrequest;
            sd0   <= word(imem_addr);
            sv[1] <= sv[0];
            sd1   <= sd0;
            if (imem_read && imem_waitrequest) stall_used <= stall_used + 1;
            if (imem_read && !imem_waitrequest && imem_addr == 32'h8) acc8 <= acc8 + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Monitor: scoreboard pops on each handshake; a stalled request must persist.
    initial begin
        logic        prev_stall;
        logic [31:0] prev_addr;
        exp_t        e;
        prev_stall = 1'b0;
        prev_addr  = 32'h0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (prev_stall) begin
                    chk("hold_read", {31'b0, imem_read}, 32'd1);
                    chk("hold_addr", imem_addr, prev_addr);
                end
                if (if_valid && if_ready && !redirect_valid) begin
                    if (q.size() == 0) begin
                        n_chk++;
                        n_err++;
                        $display("FAIL unexpected_deliver: got pc %h, required no delivery", if_pc);
                    end else begin
                        e = q.pop_front();
                        chk("if_pc", if_pc, e.pc);
                        chk("if_instr", if_instr, e.instr);
                    end
                end
            end
            prev_stall = rst && imem_read && imem_waitrequest;
            prev_addr  = imem_addr;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect_pc    = pc;
        redirect_valid = 1'b1;
        tick();
        redirect_valid = 1'b0;
    endtask

    task automatic run_expect(input logic [31:0] start, input int n, output int cyc);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.pc    = start + 32'(4 * i);
            e.instr = word(e.pc);
            q.push_back(e);
        end
        if_ready = 1'b1;
        cyc = 0;
        while (q.size() != 0 && cyc < 200) begin
            tick();
            cyc++;
        end
        if_ready = 1'b0;
        if (q.size() != 0) begin
            n_chk++;
            n_err++;
            $display("FAIL drain_timeout: %0d entries undelivered, required 0", q.size());
            q.delete();
        end
    endtask

    task automatic check_reset();
        chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
        chk("rst_imem_read", {31'b0, imem_read}, 32'd0);
        chk("rst_imem_addr", imem_addr, 32'h0);
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_if_instr", if_instr, 32'h0000_0013);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        if_ready       = 1'b0;
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset();

        // Stream with zero-wait, latency-1 memory: 0,4,8,... back to back.
        rst = 1'b1;
        run_expect(32'h0, 16, cyc);
        chk("stream_cycles", 32'(cyc), 32'd18);

        // Decode stalls: issue stops with 4 words buffered, next PC is 0x50.
        repeat (10) tick();
        chk("stall_read_off", {31'b0, imem_read}, 32'd0);
        chk("stall_next_addr", imem_addr, 32'h50);
        run_expect(32'h40, 12, cyc);

        // Latency-2 memory: redirect to 0x40 while reads are in flight.
        repeat (10) tick();
        lat = 2;
        do_redirect(32'h80);
        tick();
        tick();
        if_ready = 1'b1;
        do_redirect(32'h40);
        chk("flush_if_valid", {31'b0, if_valid}, 32'd0);
        run_expect(32'h40, 8, cyc);

        // Redirect to 0x103 while the request for 0x10 is stalled.
        repeat (10) tick();
        stall_addr = 32'h10;
        stall_req  = 1000;
        do_redirect(32'h0);
        run_expect(32'h0, 4, cyc);
        repeat (3) tick();
        chk("stalled_read", {31'b0, imem_read}, 32'd1);
        chk("stalled_addr", imem_addr, 32'h10);
        if_ready = 1'b1;
        do_redirect(32'h103);
        chk("holdst_addr", imem_addr, 32'h10);
        chk("holdst_read", {31'b0, imem_read}, 32'd1);
        tick();
        chk("holdst_addr2", imem_addr, 32'h10);
        stall_req = 0;
        run_expect(32'h100, 6, cyc);
`ifdef IMEM_FETCH_PERF_EN
        chk("perf_flush", perf_flush_cnt, 32'd4);
        chk("perf_wait", perf_wait_cnt, 32'(stall_used));
        chk("perf_drop", perf_drop_cnt, 32'd4);
`endif

        // Reset while reads are in flight.
        tick();
        rst = 1'b0;
        #1;
        check_reset();
`ifdef IMEM_FETCH_PERF_EN
        chk("rst_perf_wait", perf_wait_cnt, 32'd0);
        chk("rst_perf_flush", perf_flush_cnt, 32'd0);
        chk("rst_perf_drop", perf_drop_cnt, 32'd0);
`endif
        lat        = 1;
        stall_addr = 32'h8;
        stall_req  = 3;
        repeat (3) tick();
        chk("rst_hold_read", {31'b0, imem_read}, 32'd0);
        rst = 1'b1;
        #1;
        chk("release_addr", imem_addr, 32'h0);
        chk("release_read", {31'b0, imem_read}, 32'd1);

        // Three waitrequest cycles on 0x8, then 0x8 accepted exactly once.
        run_expect(32'h0, 16, cyc);
        chk("acc_0x8_once", 32'(acc8), 32'd1);
        chk("wait_cycles", 32'(stall_used), 32'd3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
